v_load_wb: RTL
==============

# v_load_wb

Load writeback stage sitting directly downstream of the vector load unit. It captures each completed 512-bit load result (one `l_done` pulse), then writes it into the vector register file as 1, 2 or 4 consecutive 128-bit registers starting at `vd`, one register per clock. A one-deep pending slot absorbs a second load result that completes while a writeback is still in progress.

## Interface
- `VLEN`, 128, width of one vector register in bits.
- `VREG_AW`, 5, vector register address width (32 registers).
- `clk`  in  1  clock; all state updates on the rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `ld_valid`  in  1  load result valid; driven by the load unit's done pulse.
- `ld_data`  in  512  load result; register `vd+k` occupies bits `[128k+127:128k]`.
- `ld_lmul`  in  3  LMUL encoding of the load: 000→1 reg, 001→2, 010→4, any other value→1.
- `ld_vd`  in  `VREG_AW`  destination base register.
- `ld_ready`  out  1  high when the pending slot is empty.
- `busy`  out  1  high while writes are being issued (state WRITE).
- `vrf_we`  out  1  register file write enable.
- `vrf_waddr`  out  `VREG_AW`  register file write address.
- `vrf_wdata`  out  `VLEN`  register file write data.
- `wb_done`  out  1  one-cycle pulse coincident with the last write of a load.
- `ovf_err`  out  1  sticky overflow flag; cleared only by reset.

## Operation
- Storage: active slot (data 512, base vd, nregs 3-bit, write index 2-bit) and pending slot (same fields plus valid bit).
- `nregs` decoded from lmul at capture: 000→1, 001→2, 010→4, else→1. Only the decoded count of 128-bit lanes is written; upper lanes are ignored.
- States: IDLE, WRITE.
- IDLE: `ld_valid`=1 → load active slot from inputs, index=0, go to WRITE. Otherwise stay.
- WRITE, each cycle: `vrf_we`=1, `vrf_waddr`=(vd+index) mod 32, `vrf_wdata`=active data lane `index`; index increments.
- Last write (index==nregs-1): `wb_done`=1. Next action, by priority:
  - pending valid → pending moves to active, index=0, stay in WRITE; if `ld_valid` also high, inputs go to pending (stays valid).
  - pending empty and `ld_valid` → inputs load active directly, stay in WRITE.
  - otherwise → IDLE.
- Non-last WRITE cycle with `ld_valid`: pending empty → capture into pending; pending full → input dropped, `ovf_err` set.
- `ld_ready` = !pending valid. Dropping input only happens when the producer ignores `ld_ready`.
- Address arithmetic is 5-bit modulo: vd=30, nregs=4 writes 30, 31, 0, 1. There is no alignment check.

## Timing
- Reset (async assert, any state): state=IDLE, both slots invalid, index=0, `vrf_we`=0, `vrf_waddr`=0, `vrf_wdata`=0, `wb_done`=0, `busy`=0, `ovf_err`=0, `ld_ready`=1. A writeback in progress is abandoned and no further writes are issued.
- `vrf_we`, `vrf_waddr`, `vrf_wdata`, `wb_done` and `busy` are registered outputs.
- Latency: `ld_valid` sampled at edge N while idle → first `vrf_we` during cycle N+1; last write in cycle N+nregs.
- Back-to-back: the next load's first write immediately follows the previous load's last write, with no idle cycle.
- Throughput: one register per cycle; sustained rate is one load per nregs cycles.
- `ld_valid` is a single-cycle pulse per result. Each high cycle is treated as a distinct result.

## Test plan
- lmul=000, vd=5, data lane0=0x0123…CDEF → one write: addr 5, that data, `wb_done` in the same cycle, `busy` low the next cycle.
- lmul=010, vd=8, lanes L0..L3 → writes (8,L0),(9,L1),(10,L2),(11,L3) in 4 consecutive cycles; `wb_done` only on the 4th write.
- lmul=001 vd=2 followed 1 cycle later by lmul=000 vd=20 → `ld_ready` drops, writes 2, 3, 20 with no gap, `ld_ready` returns high.
- lmul=010 busy, two further `ld_valid` pulses before completion → 1st is held pending, 2nd sets `ovf_err`=1 (sticky); the written sequence omits the dropped load.
- lmul=010, vd=30 → write addresses 30, 31, 0, 1. lmul=111, vd=7 → a single write to 7 with lane 0.
- Assert `nrst` low during the 2nd write of a 4-register load → all outputs go to reset values immediately and no writes occur after release; a fresh load afterwards completes normally.

Source files
------------

// File: rtl/v_load_wb.sv
// Load writeback stage: captures 512-bit load results and streams them into the
// vector register file as 1, 2 or 4 consecutive registers, with a one-deep pending slot.
module v_load_wb #(
  parameter int VLEN    = 128,
  parameter int VREG_AW = 5
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 ld_valid,
  input  logic [4*VLEN-1:0]    ld_data,
  input  logic [2:0]           ld_lmul,
  input  logic [VREG_AW-1:0]   ld_vd,
  output logic                 ld_ready,
  output logic                 busy,
  output logic                 vrf_we,
  output logic [VREG_AW-1:0]   vrf_waddr,
  output logic [VLEN-1:0]      vrf_wdata,
  output logic                 wb_done,
  output logic                 ovf_err
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t              state, state_nxt;
  logic [4*VLEN-1:0]   act_data, act_data_nxt, pend_data, pend_data_nxt;
  logic [VREG_AW-1:0]  act_vd, act_vd_nxt, pend_vd, pend_vd_nxt;
  logic [2:0]          act_nregs, act_nregs_nxt, pend_nregs, pend_nregs_nxt;
  logic [1:0]          idx, idx_nxt;
  logic                pend_valid, pend_valid_nxt, ovf_nxt;
  logic                last;

  logic                emit, emit_last;
  logic [4*VLEN-1:0]   emit_data;
  logic [VREG_AW-1:0]  emit_vd, emit_addr;
  logic [2:0]          emit_nregs;
  logic [1:0]          emit_idx;
  logic [VLEN-1:0]     emit_lane;

  function automatic logic [2:0] decode_nregs(input logic [2:0] lmul);
    case (lmul)
      3'b001:  return 3'd2;
      3'b010:  return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  assign last     = ({1'b0, idx} == act_nregs - 3'd1);
  assign ld_ready = !pend_valid;

  // The emit_* signals describe the write to present in the coming cycle;
  // outputs are registered, so the write is decided one edge ahead.
  always_comb begin
    state_nxt      = state;
    act_data_nxt   = act_data;
    act_vd_nxt     = act_vd;
    act_nregs_nxt  = act_nregs;
    pend_data_nxt  = pend_data;
    pend_vd_nxt    = pend_vd;
    pend_nregs_nxt = pend_nregs;
    pend_valid_nxt = pend_valid;
    idx_nxt        = idx;
    ovf_nxt        = ovf_err;
    emit           = 1'b0;
    emit_data      = act_data;
    emit_vd        = act_vd;
    emit_nregs     = act_nregs;
    emit_idx       = idx;
    case (state)
      IDLE: begin
        if (ld_valid) begin
          state_nxt     = WRITE;
          act_data_nxt  = ld_data;
          act_vd_nxt    = ld_vd;
          act_nregs_nxt = decode_nregs(ld_lmul);
          idx_nxt       = 2'd0;
          emit          = 1'b1;
          emit_data     = ld_data;
          emit_vd       = ld_vd;
          emit_nregs    = decode_nregs(ld_lmul);
          emit_idx      = 2'd0;
        end
      end
      WRITE: begin
        if (!last) begin
          idx_nxt  = idx + 2'd1;
          emit     = 1'b1;
          emit_idx = idx + 2'd1;
          if (ld_valid) begin
            if (!pend_valid) begin
              pend_valid_nxt = 1'b1;
              pend_data_nxt  = ld_data;
              pend_vd_nxt    = ld_vd;
              pend_nregs_nxt = decode_nregs(ld_lmul);
            end else begin
              ovf_nxt = 1'b1;
            end
          end
        end else if (pend_valid) begin
          // Pending result goes first; a new input refills the slot just vacated.
          act_data_nxt   = pend_data;
          act_vd_nxt     = pend_vd;
          act_nregs_nxt  = pend_nregs;
          idx_nxt        = 2'd0;
          emit           = 1'b1;
          emit_data      = pend_data;
          emit_vd        = pend_vd;
          emit_nregs     = pend_nregs;
          emit_idx       = 2'd0;
          pend_valid_nxt = ld_valid;
          if (ld_valid) begin
            pend_data_nxt  = ld_data;
            pend_vd_nxt    = ld_vd;
            pend_nregs_nxt = decode_nregs(ld_lmul);
          end
        end else if (ld_valid) begin
          act_data_nxt  = ld_data;
          act_vd_nxt    = ld_vd;
          act_nregs_nxt = decode_nregs(ld_lmul);
          idx_nxt       = 2'd0;
          emit          = 1'b1;
          emit_data     = ld_data;
          emit_vd       = ld_vd;
          emit_nregs    = decode_nregs(ld_lmul);
          emit_idx      = 2'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (emit_idx)
      2'd0:    emit_lane = emit_data[VLEN-1:0];
      2'd1:    emit_lane = emit_data[2*VLEN-1:VLEN];
      2'd2:    emit_lane = emit_data[3*VLEN-1:2*VLEN];
      default: emit_lane = emit_data[4*VLEN-1:3*VLEN];
    endcase
  end

  assign emit_addr = emit_vd + VREG_AW'(emit_idx);
  assign emit_last = ({1'b0, emit_idx} == emit_nregs - 3'd1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      act_data   <= '0;
      act_vd     <= '0;
      act_nregs  <= 3'd1;
      pend_data  <= '0;
      pend_vd    <= '0;
      pend_nregs <= 3'd1;
      pend_valid <= 1'b0;
      idx        <= 2'd0;
      ovf_err    <= 1'b0;
      vrf_we     <= 1'b0;
      vrf_waddr  <= '0;
      vrf_wdata  <= '0;
      wb_done    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      act_data   <= act_data_nxt;
      act_vd     <= act_vd_nxt;
      act_nregs  <= act_nregs_nxt;
      pend_data  <= pend_data_nxt;
      pend_vd    <= pend_vd_nxt;
      pend_nregs <= pend_nregs_nxt;
      pend_valid <= pend_valid_nxt;
      idx        <= idx_nxt;
      ovf_err    <= ovf_nxt;
      vrf_we     <= emit;
      vrf_waddr  <= emit ? emit_addr : '0;
      vrf_wdata  <= emit ? emit_lane : '0;
      wb_done    <= emit && emit_last;
      busy       <= (state_nxt == WRITE);
    end
  end

endmodule
